// File: rtl/cepstral_accum.sv
// cepstral_accum: sums 13 product lanes over a frame, then streams scaled, saturated sums as a 13-beat packet
// Ports: clk/rst (sync, active-high); mult_p0..mult_p12, mult_valid, mult_ready = product input handshake;
// tdata_out, tuser_out (coefficient index), tlast_out, tvalid_out, tready_in = output stream handshake.
module cepstral_accum #(
  parameter int N_SAMPLES = 64,
  parameter int PROD_W    = 32,
  parameter int ACC_W     = 42,
  parameter int SHIFT     = 10,
  parameter int OUT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] mult_p0,
  input  logic [PROD_W-1:0] mult_p1,
  input  logic [PROD_W-1:0] mult_p2,
  input  logic [PROD_W-1:0] mult_p3,
  input  logic [PROD_W-1:0] mult_p4,
  input  logic [PROD_W-1:0] mult_p5,
  input  logic [PROD_W-1:0] mult_p6,
  input  logic [PROD_W-1:0] mult_p7,
  input  logic [PROD_W-1:0] mult_p8,
  input  logic [PROD_W-1:0] mult_p9,
  input  logic [PROD_W-1:0] mult_p10,
  input  logic [PROD_W-1:0] mult_p11,
  input  logic [PROD_W-1:0] mult_p12,
  input  logic              mult_valid,
  output logic              mult_ready,
  output logic [OUT_W-1:0]  tdata_out,
  output logic [3:0]        tuser_out,
  output logic              tlast_out,
  output logic              tvalid_out,
  input  logic              tready_in
);
  localparam int CW = $clog2(N_SAMPLES + 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
  typedef enum logic {ACCUM, DRAIN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q [13];
  logic signed [ACC_W-1:0] acc_d [13];
  logic [PROD_W-1:0] prod [13];
  logic signed [ACC_W-1:0] sh;
  assign prod = '{mult_p0, mult_p1, mult_p2, mult_p3, mult_p4, mult_p5, mult_p6,
                  mult_p7, mult_p8, mult_p9, mult_p10, mult_p11, mult_p12};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    if (state_q == ACCUM) begin
      if (mult_valid) begin
        for (int k = 0; k < 13; k++) acc_d[k] = acc_q[k] + ACC_W'($signed(prod[k]));
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N_SAMPLES - 1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
    end else if (tready_in) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == 4'd12) begin
        state_d = ACCUM;
        idx_d   = '0;
        for (int k = 0; k < 13; k++) acc_d[k] = '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      idx_q   <= '0;
      for (int k = 0; k < 13; k++) acc_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end
  // idx stays 0 outside DRAIN, so tuser_out needs no gating
  assign sh         = acc_q[idx_q] >>> SHIFT;
  assign mult_ready = state_q == ACCUM;
  assign tvalid_out = state_q == DRAIN;
  assign tuser_out  = idx_q;
  assign tlast_out  = tvalid_out && idx_q == 4'd12;
  assign tdata_out  = !tvalid_out   ? '0 :
                      sh > SAT_MAX  ? {1'b0, {(OUT_W-1){1'b1}}} :
                      sh < SAT_MIN  ? {1'b1, {(OUT_W-1){1'b0}}} : sh[OUT_W-1:0];
endmodule

// File: tb/tb_cepstral_accum.sv
// tb_cepstral_accum: randomized and directed stimulus against a frame-level sum/saturate model
module tb_cepstral_accum;
  localparam int NS = 4;
  logic clk = 0, rst = 1;
  logic mult_valid = 0, tready_in = 1;
  logic [31:0] p [13];
  logic mult_ready, tvalid_out, tlast_out, mult_ready2, tvalid_out2, tlast_out2;
  logic [15:0] tdata_out, tdata_out2;
  logic [3:0] tuser_out, tuser_out2;
  always #5 clk = ~clk;

  cepstral_accum #(.N_SAMPLES(NS), .PROD_W(32), .ACC_W(42), .SHIFT(0), .OUT_W(16)) dut (
    .clk(clk), .rst(rst),
    .mult_p0(p[0]), .mult_p1(p[1]), .mult_p2(p[2]), .mult_p3(p[3]), .mult_p4(p[4]),
    .mult_p5(p[5]), .mult_p6(p[6]), .mult_p7(p[7]), .mult_p8(p[8]), .mult_p9(p[9]),
    .mult_p10(p[10]), .mult_p11(p[11]), .mult_p12(p[12]),
    .mult_valid(mult_valid), .mult_ready(mult_ready), .tdata_out(tdata_out),
    .tuser_out(tuser_out), .tlast_out(tlast_out), .tvalid_out(tvalid_out), .tready_in(tready_in));

  cepstral_accum #(.N_SAMPLES(NS), .PROD_W(32), .ACC_W(42), .SHIFT(2), .OUT_W(16)) dut_s2 (
    .clk(clk), .rst(rst),
    .mult_p0(p[0]), .mult_p1(p[1]), .mult_p2(p[2]), .mult_p3(p[3]), .mult_p4(p[4]),
    .mult_p5(p[5]), .mult_p6(p[6]), .mult_p7(p[7]), .mult_p8(p[8]), .mult_p9(p[9]),
    .mult_p10(p[10]), .mult_p11(p[11]), .mult_p12(p[12]),
    .mult_valid(mult_valid), .mult_ready(mult_ready2), .tdata_out(tdata_out2),
    .tuser_out(tuser_out2), .tlast_out(tlast_out2), .tvalid_out(tvalid_out2), .tready_in(tready_in));

  typedef struct {logic [15:0] d0; logic [15:0] d2; logic [3:0] u; logic l;} beat_t;
  beat_t beats [$];
  longint sum [13];
  int cnt = 0, n_chk = 0, n_pass = 0;
  bit armed = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] sat(longint s, int shamt);
    longint v;
    v = s >>> shamt;
    return v > 32767 ? 16'h7fff : v < -32768 ? 16'h8000 : v[15:0];
  endfunction

  // model: an output packet is pending iff the block is draining
  always @(negedge clk) begin
    bit ev;
    beat_t b;
    ev = beats.size() != 0;
    if (armed) begin
      chk("mult_ready", mult_ready, !ev);
      chk("mult_ready_s2", mult_ready2, !ev);
      chk("tvalid", tvalid_out, ev);
      chk("tvalid_s2", tvalid_out2, ev);
      if (ev) begin
        chk("tdata", tdata_out, beats[0].d0);
        chk("tdata_s2", tdata_out2, beats[0].d2);
        chk("tuser", tuser_out, beats[0].u);
        chk("tuser_s2", tuser_out2, beats[0].u);
        chk("tlast", tlast_out, beats[0].l);
        chk("tlast_s2", tlast_out2, beats[0].l);
      end else begin
        chk("idle_tdata", tdata_out, 0);
        chk("idle_tuser", tuser_out, 0);
        chk("idle_tlast", tlast_out, 0);
      end
    end
    if (rst) begin
      beats.delete();
      foreach (sum[k]) sum[k] = 0;
      cnt = 0;
      armed = 1;
    end else if (armed) begin
      if (ev && tready_in) void'(beats.pop_front());
      else if (!ev && mult_valid) begin
        foreach (sum[k]) sum[k] += longint'($signed(p[k]));
        cnt++;
        if (cnt == NS) begin
          for (int k = 0; k < 13; k++) begin
            b.d0 = sat(sum[k], 0);
            b.d2 = sat(sum[k], 2);
            b.u  = 4'(k);
            b.l  = k == 12;
            beats.push_back(b);
            sum[k] = 0;
          end
          cnt = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(logic [31:0] v);
    foreach (p[k]) p[k] = v;
  endtask

  task automatic idle(int n);
    mult_valid = 0;
    repeat (n) step();
  endtask

  task automatic feed(int n);
    mult_valid = 1;
    repeat (n) step();
    mult_valid = 0;
  endtask

  task automatic wait_idx(int i);
    for (int c = 0; c < 60; c++) begin
      step();
      if (tvalid_out && tuser_out == 4'(i)) return;
    end
    chk("wait_idx_timeout", 0, 1);
  endtask

  initial begin
    int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    set_all(0);
    repeat (2) step();
    rst = 0;
    for (int k = 0; k < 13; k++) p[k] = 32'(k + 1);
    feed(NS);
    idle(16);
    p[0] = 32'hffff_ffff; p[1] = 32'h7fff_ffff; p[2] = 32'h8000_0000; p[3] = 32'd400;
    for (int k = 4; k < 13; k++) p[k] = $urandom;
    feed(NS);
    idle(16);
    set_all(1);
    foreach (pat[i]) begin
      mult_valid = pat[i][0];
      step();
    end
    mult_valid = 0;
    wait_idx(6);
    tready_in = 0;
    repeat (5) step();
    tready_in = 1;
    idle(12);
    set_all(1);
    mult_valid = 1;
    repeat (NS) step();
    set_all(2);
    repeat (13 + NS) step();
    idle(16);
    set_all(5);
    feed(2);
    rst = 1;
    step();
    rst = 0;
    idle(5);
    set_all(3);
    feed(NS);
    wait_idx(5);
    rst = 1;
    step();
    rst = 0;
    idle(4);
    for (int c = 0; c < 400; c++) begin
      mult_valid = $urandom_range(0, 3) != 0;
      tready_in  = $urandom_range(0, 3) != 0;
      foreach (p[k]) p[k] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4000)) - 32'd2000;
      step();
    end
    tready_in = 1;
    idle(20);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
